ov7670_frame_writer: RTL and testbench
======================================

Name: ov7670_frame_writer

Overview:
- Sits directly downstream of the OV7670 controller.
- Consumes its newPixel/pixelData stream of RGB565 pixels (already in the system clk domain) plus a frame-start strobe.
- Generates linear frame-buffer addresses and writes each pixel to an external memory port through a req/ack handshake.
- A small address+data FIFO absorbs memory stalls. The block reports frame completion and overflow.

Parameters:
- H_RES, 320, pixels per line.
- V_RES, 240, lines per frame.
- ADDR_W, 17, memory address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- FIFO_DEPTH, 4, FIFO entries; must be a power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- captureEn  in  1  level; arms capture; when held high, capture runs continuously frame after frame.
- frameStart  in  1  one-cycle pulse marking the start of a frame.
- newPixel  in  1  one-cycle pulse; pixelData is valid this cycle.
- pixelData  in  16  RGB565 pixel.
- memAddr  out  ADDR_W  write address = row*H_RES + col.
- memWrData  out  16  write data.
- memWrReq  out  1  write request.
- memWrAck  in  1  memory accepted the current request.
- frameDone  out  1  one-cycle pulse when the last pixel of a frame has been acked.
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full.
- busy  out  1  high in CAPTURE or DRAIN.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; col, row, write pointer, read pointer and count all = 0.
  - Outputs: memWrReq=0, memAddr=0, memWrData=0, frameDone=0, overflow=0, busy=0.
- States:
  - IDLE: if captureEn, go to WAIT_FRAME.
  - WAIT_FRAME: on frameStart, clear col/row, go to CAPTURE. If captureEn drops, go to IDLE.
  - CAPTURE: accepts pixels. After the pixel at col=H_RES-1, row=V_RES-1 is accepted or dropped, go to DRAIN.
  - DRAIN: when the FIFO is empty and memWrReq=0, pulse frameDone for one cycle. Then go to WAIT_FRAME if captureEn=1, else IDLE.
- Pixel intake:
  - Only in CAPTURE. newPixel is ignored in every other state.
  - Each newPixel advances col; col wraps H_RES-1 -> 0 and increments row.
  - If the FIFO is not full, push {row*H_RES+col, pixelData}.
  - If the FIFO is full, set overflow and drop the pixel; col/row still advance so later addresses stay correct.
  - The address multiply-add is computed combinationally from the counters, truncated to ADDR_W.
- FIFO:
  - Push and pop in the same cycle are both performed.
  - When full, a same-cycle pop makes room and the push is accepted, with no overflow.
  - count = 0..FIFO_DEPTH; the pointers wrap modulo FIFO_DEPTH.
- Memory handshake:
  - memWrReq is registered and is high whenever the FIFO is non-empty. memAddr/memWrData show the head entry and stay stable while memWrReq=1 and memWrAck=0.
  - On a cycle with memWrReq=1 and memWrAck=1, the head is popped.
  - The next entry, if any, is presented on the following cycle with memWrReq held high; otherwise memWrReq falls.
  - memWrAck while memWrReq=0 is ignored.
- Latency: newPixel at cycle N into an empty FIFO gives memWrReq=1 with that pixel at cycle N+1.
- frameStart while in CAPTURE or DRAIN:
  - Restarts the frame: col/row are cleared and state goes to CAPTURE.
  - FIFO contents still drain normally; frameDone is not pulsed for the aborted frame.
- captureEn dropping during CAPTURE:
  - The current frame completes normally, then state goes to IDLE.
- overflow clears only on reset, or on the WAIT_FRAME->CAPTURE transition.
- busy = (state==CAPTURE || state==DRAIN).

Test Plan:
- Nominal: captureEn=1, frameStart, 76800 newPixel pulses every 4th cycle, memWrAck tied high -> 76800 writes; addr 0..76799 in order; data matches; one frameDone pulse; overflow=0.
- Stall: H_RES=4, V_RES=2; 8 pixels back-to-back; memWrAck held low for 10 cycles then high -> first 4 pixels written at addr 0..3; pixels 5-8 dropped; overflow=1; frameDone after the 4th ack.
- Full plus simultaneous pop: FIFO full, and on a cycle with memWrAck=1 newPixel arrives -> pixel accepted, count stays 4, overflow=0.
- Mid-frame restart: frameStart after 100 pixels -> the next pixel is written to addr 0; the 100 earlier pixels still acked; only one frameDone, at the end of the restarted frame.
- Single-shot: captureEn drops mid-frame -> frame finishes, frameDone pulses, state returns to IDLE; a following frameStart produces no writes.
- Async reset: assert reset low mid-DRAIN with memWrReq=1 -> memWrReq=0 and busy=0 immediately (no clock edge); after release, no writes until captureEn and frameStart.

Source files
------------

// File: rtl/ov7670_frame_writer_if.sv
// Write port toward the external frame-buffer memory.
// The master presents one address/data word per request and holds it until the memory acks.
interface ov7670_frame_writer_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] memAddr;
    logic [15:0]       memWrData;
    logic              memWrReq;
    logic              memWrAck;

    modport master (
        output memAddr,
        output memWrData,
        output memWrReq,
        input  memWrAck
    );

    modport slave (
        input  memAddr,
        input  memWrData,
        input  memWrReq,
        output memWrAck
    );
endinterface

// File: rtl/ov7670_frame_writer.sv
// Turns the OV7670 pixel stream into linear frame-buffer writes.
// A small address+data FIFO rides out memory stalls; frame completion and drops are reported.
module ov7670_frame_writer #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         captureEn,
    input  logic                         frameStart,
    input  logic                         newPixel,
    input  logic [15:0]                  pixelData,
    ov7670_frame_writer_if.master        mem,
    output logic                         frameDone,
    output logic                         overflow,
    output logic                         busy
);
    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        CAPTURE,
        DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               req_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  fifo_addr_q [FIFO_DEPTH];
    logic [15:0]        fifo_data_q [FIFO_DEPTH];

    logic               push, pop, fifo_full, last_pixel;
    logic [ADDR_W-1:0]  pix_addr;

    assign pix_addr   = ADDR_W'(row_q) * ADDR_W'(H_RES) + ADDR_W'(col_q);
    assign pop        = req_q & mem.memWrAck;
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign last_pixel = (col_q == COL_W'(H_RES - 1)) && (row_q == ROW_W'(V_RES - 1));
    assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (captureEn) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (frameStart) begin
                    state_d = CAPTURE;
                    col_d   = '0;
                    row_d   = '0;
                    ovf_d   = 1'b0;
                end else if (!captureEn) begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                if (frameStart) begin
                    col_d = '0;
                    row_d = '0;
                end else if (newPixel) begin
                    // A full FIFO still takes the pixel if the head leaves this cycle.
                    if (!fifo_full || pop) push  = 1'b1;
                    else                   ovf_d = 1'b1;
                    if (col_q == COL_W'(H_RES - 1)) begin
                        col_d = '0;
                        row_d = (row_q == ROW_W'(V_RES - 1)) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_pixel) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (frameStart) begin
                    state_d = CAPTURE;
                    col_d   = '0;
                    row_d   = '0;
                end else if (count_q == '0 && !req_q) begin
                    done_d  = 1'b1;
                    state_d = captureEn ? WAIT_FRAME : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the FIFO storage is reset because its head drives memAddr/memWrData, which must read 0 out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            req_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= pix_addr;
                fifo_data_q[wr_ptr_q] <= pixelData;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            req_q   <= (count_d != '0);
        end
    end

    assign mem.memAddr   = fifo_addr_q[rd_ptr_q];
    assign mem.memWrData = fifo_data_q[rd_ptr_q];
    assign mem.memWrReq  = req_q;
    assign frameDone     = done_q;
    assign overflow      = ovf_q;
    assign busy          = (state_q == CAPTURE) || (state_q == DRAIN);
endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Bench for ov7670_frame_writer: a 16x10 instance for streaming scenarios, a 4x2 instance for the stall case.
// Expected writes are queued as pixels are driven and matched as the memory handshakes complete.
module tb_ov7670_frame_writer;
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic a_cap = 0, a_fs = 0, a_np = 0;
    logic [15:0] a_pd = '0;
    logic a_done, a_ovf, a_busy;
    logic b_cap = 0, b_fs = 0, b_np = 0;
    logic [15:0] b_pd = '0;
    logic b_done, b_ovf, b_busy;

    ov7670_frame_writer_if #(.ADDR_W(8)) a_mem ();
    ov7670_frame_writer_if #(.ADDR_W(3)) b_mem ();

    ov7670_frame_writer #(.H_RES(16), .V_RES(10), .ADDR_W(8), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .captureEn(a_cap), .frameStart(a_fs),
        .newPixel(a_np), .pixelData(a_pd), .mem(a_mem),
        .frameDone(a_done), .overflow(a_ovf), .busy(a_busy)
    );

    ov7670_frame_writer #(.H_RES(4), .V_RES(2), .ADDR_W(3), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .captureEn(b_cap), .frameStart(b_fs),
        .newPixel(b_np), .pixelData(b_pd), .mem(b_mem),
        .frameDone(b_done), .overflow(b_ovf), .busy(b_busy)
    );

    always #5 clk = ~clk;

    exp_t a_q[$];
    exp_t b_q[$];
    exp_t a_e, b_e;
    int vectors = 0, miscompares = 0;
    int a_done_cnt = 0, b_done_cnt = 0;
    int a_col = 0, a_row = 0, b_col = 0, b_row = 0;

    // Handshakes are observed on the falling edge; req&ack here completes on the next rising edge.
    always @(negedge clk) begin
        if (a_mem.memWrReq && a_mem.memWrAck) begin
            vectors++;
            if (a_q.size() == 0) begin
                miscompares++;
                $display("FAIL a_write: got addr=%0d data=%h, expected no write", a_mem.memAddr, a_mem.memWrData);
            end else begin
                a_e = a_q.pop_front();
                if (16'(a_mem.memAddr) !== a_e.addr || a_mem.memWrData !== a_e.data) begin
                    miscompares++;
                    $display("FAIL a_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             a_mem.memAddr, a_mem.memWrData, a_e.addr, a_e.data);
                end
            end
        end
        if (b_mem.memWrReq && b_mem.memWrAck) begin
            vectors++;
            if (b_q.size() == 0) begin
                miscompares++;
                $display("FAIL b_write: got addr=%0d data=%h, expected no write", b_mem.memAddr, b_mem.memWrData);
            end else begin
                b_e = b_q.pop_front();
                if (16'(b_mem.memAddr) !== b_e.addr || b_mem.memWrData !== b_e.data) begin
                    miscompares++;
                    $display("FAIL b_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             b_mem.memAddr, b_mem.memWrData, b_e.addr, b_e.data);
                end
            end
        end
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_pixel(input bit accept);
        a_pd = 16'($urandom);
        a_np = 1'b1;
        if (accept) a_q.push_back({16'(a_row * 16 + a_col), a_pd});
        a_col++;
        if (a_col == 16) begin
            a_col = 0;
            a_row = (a_row == 9) ? 0 : a_row + 1;
        end
        tick();
        a_np = 1'b0;
    endtask

    task automatic a_pixels(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            a_pixel(1'b1);
            repeat (gap - 1) tick();
        end
    endtask

    task automatic a_start_frame();
        a_fs = 1'b1;
        tick();
        a_fs = 1'b0;
        a_col = 0;
        a_row = 0;
    endtask

    task automatic b_pixel(input bit accept);
        b_pd = 16'($urandom);
        b_np = 1'b1;
        if (accept) b_q.push_back({16'(b_row * 4 + b_col), b_pd});
        b_col++;
        if (b_col == 4) begin
            b_col = 0;
            b_row = (b_row == 1) ? 0 : b_row + 1;
        end
        tick();
        b_np = 1'b0;
    endtask

    task automatic a_wait_done(input int target, input string name);
        int cycles = 0;
        while (a_done_cnt < target && cycles < 3000) begin
            tick();
            cycles++;
        end
        repeat (3) tick();
        vectors++;
        if (a_done_cnt !== target) begin
            miscompares++;
            $display("FAIL %s_done: frameDone pulses=%0d, expected %0d", name, a_done_cnt, target);
        end
        vectors++;
        if (a_q.size() !== 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d writes outstanding, expected 0", name, a_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_mem.memWrAck = 1'b0;
        b_mem.memWrAck = 1'b0;
        #23;
        vectors++;
        if (a_mem.memWrReq !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", a_mem.memWrReq); end
        vectors++;
        if (a_mem.memAddr !== 8'd0) begin miscompares++; $display("FAIL reset_addr: got %0d expected 0", a_mem.memAddr); end
        vectors++;
        if (a_mem.memWrData !== 16'd0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", a_mem.memWrData); end
        vectors++;
        if (a_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", a_done); end
        vectors++;
        if (a_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", a_ovf); end
        vectors++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b/%b expected 0/0", a_busy, b_busy); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        logic [15:0] first;
        a_mem.memWrAck = 1'b1;
        a_cap = 1'b1;
        tick();
        a_start_frame();
        a_pixel(1'b1);
        first = a_q[0].data;
        vectors++;
        if (a_mem.memWrReq !== 1'b1 || a_mem.memAddr !== 8'd0 || a_mem.memWrData !== first) begin
            miscompares++;
            $display("FAIL nominal_latency: got req=%b addr=%0d data=%h, expected req=1 addr=0 data=%h",
                     a_mem.memWrReq, a_mem.memAddr, a_mem.memWrData, first);
        end
        repeat (3) tick();
        a_pixels(159, 4);
        a_wait_done(1, "nominal");
        vectors++;
        if (a_ovf !== 1'b0 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL nominal_flags: got ovf=%b busy=%b, expected 0/0", a_ovf, a_busy);
        end
    endtask

    task automatic test_full_pop();
        a_mem.memWrAck = 1'b0;
        a_start_frame();
        repeat (4) a_pixel(1'b1);
        a_mem.memWrAck = 1'b1;
        a_pixel(1'b1);
        a_mem.memWrAck = 1'b0;
        vectors++;
        if (a_ovf !== 1'b0) begin miscompares++; $display("FAIL full_pop_ovf: got %b expected 0", a_ovf); end
        a_pixel(1'b0);
        vectors++;
        if (a_ovf !== 1'b1) begin miscompares++; $display("FAIL full_after_pop_ovf: got %b expected 1", a_ovf); end
        a_mem.memWrAck = 1'b1;
        a_pixels(154, 2);
        a_wait_done(2, "full_pop");
    endtask

    task automatic test_restart();
        a_start_frame();
        vectors++;
        if (a_ovf !== 1'b0) begin miscompares++; $display("FAIL restart_ovf_clear: got %b expected 0", a_ovf); end
        a_pixels(100, 2);
        a_start_frame();
        vectors++;
        if (a_busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy: got %b expected 1", a_busy); end
        a_pixels(160, 2);
        a_wait_done(3, "restart");
    endtask

    task automatic test_single_shot();
        a_start_frame();
        a_pixels(50, 2);
        a_cap = 1'b0;
        a_pixels(110, 2);
        a_wait_done(4, "single_shot");
        a_fs = 1'b1;
        tick();
        a_fs = 1'b0;
        repeat (3) a_pixel(1'b0);
        repeat (6) tick();
        vectors++;
        if (a_busy !== 1'b0 || a_mem.memWrReq !== 1'b0) begin
            miscompares++;
            $display("FAIL single_shot_idle: got busy=%b req=%b, expected 0/0", a_busy, a_mem.memWrReq);
        end
    endtask

    task automatic test_stall();
        b_cap = 1'b1;
        b_mem.memWrAck = 1'b0;
        tick();
        b_fs = 1'b1;
        tick();
        b_fs = 1'b0;
        b_col = 0;
        b_row = 0;
        for (int i = 0; i < 8; i++) b_pixel(i < 4);
        vectors++;
        if (b_ovf !== 1'b1 || b_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_flags: got ovf=%b busy=%b, expected 1/1", b_ovf, b_busy);
        end
        repeat (2) tick();
        vectors++;
        if (b_done_cnt !== 0) begin miscompares++; $display("FAIL stall_early_done: got %0d pulses expected 0", b_done_cnt); end
        b_mem.memWrAck = 1'b1;
        for (int i = 0; i < 100 && b_done_cnt == 0; i++) tick();
        repeat (3) tick();
        vectors++;
        if (b_done_cnt !== 1 || b_q.size() !== 0) begin
            miscompares++;
            $display("FAIL stall_done: got pulses=%0d pending=%0d, expected 1/0", b_done_cnt, b_q.size());
        end
        vectors++;
        if (b_ovf !== 1'b1) begin miscompares++; $display("FAIL stall_ovf_sticky: got %b expected 1", b_ovf); end
        b_cap = 1'b0;
    endtask

    task automatic test_async_reset();
        a_mem.memWrAck = 1'b1;
        a_cap = 1'b1;
        tick();
        a_start_frame();
        a_pixels(156, 2);
        a_mem.memWrAck = 1'b0;
        repeat (4) a_pixel(1'b1);
        vectors++;
        if (a_busy !== 1'b1 || a_mem.memWrReq !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre: got busy=%b req=%b, expected 1/1", a_busy, a_mem.memWrReq);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (a_mem.memWrReq !== 1'b0 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_immediate: got req=%b busy=%b, expected 0/0", a_mem.memWrReq, a_busy);
        end
        a_q.delete();
        a_cap = 1'b0;
        a_mem.memWrAck = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        a_fs = 1'b1;
        tick();
        a_fs = 1'b0;
        repeat (3) a_pixel(1'b0);
        a_cap = 1'b1;
        repeat (3) a_pixel(1'b0);
        repeat (4) tick();
        vectors++;
        if (a_mem.memWrReq !== 1'b0 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_quiet: got req=%b busy=%b, expected 0/0", a_mem.memWrReq, a_busy);
        end
        a_cap = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_full_pop();
        test_restart();
        test_single_shot();
        test_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
